// File: rtl/spi_pkg.sv
// Shared SPI frame definitions used by both the master and slave sides.
// Frame = HI byte {marker 2'b10, value[13:8]} followed by LO byte value[7:0].
package spi_pkg;

   typedef enum logic {WAIT_HI = 1'b0, WAIT_LO = 1'b1} frame_state_e;

   localparam logic [1:0] HDR_MARK = 2'b10;
   localparam int         CNT_W    = 14;

   function automatic logic [7:0] pack_hi(input logic [CNT_W-1:0] value);
      return {HDR_MARK, value[CNT_W-1:8]};
   endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Registers the (already synchronised) slave select and flags its edges.
// Strobes are high in the cycle the new ss_n level is first seen.
module spi_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic ss_n,
   output logic rise,
   output logic fall
);

   logic ss_q;

   // Idle level is high, so a transfer already active at reset exit shows as a fall.
   always_ff @(posedge clk) begin
      if (reset) ss_q <= 1'b1;
      else       ss_q <= ss_n;
   end

   assign rise = ss_n & ~ss_q;
   assign fall = ~ss_n & ss_q;

endmodule

// File: rtl/spi_frame_decoder.sv
// Reassembles HI/LO byte pairs from the SPI slave into a range-checked counter value.
// Optional HI-to-LO timeout is enabled with the SPI_FRAME_TIMEOUT_EN macro.
module spi_frame_decoder
   import spi_pkg::*;
#(
   parameter int MAX_VALUE = 9999
`ifdef SPI_FRAME_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 100_000
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_done,
   input  logic             ss_n,
   output logic [CNT_W-1:0] counter,
   output logic             counter_valid,
   output logic             frame_err,
   output logic             busy
);

   // Handshake: rx_done is a one-cycle strobe qualifying rx_data (no back-pressure);
   // counter_valid / frame_err are one-cycle strobes, registered one cycle after rx_done.

   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_VALUE);

   frame_state_e     state, cur_state, nxt_state;
   logic [5:0]       hi_reg;
   logic [CNT_W-1:0] lo_val;
   logic             ss_rise, ss_fall;
   logic             rx_ok, take_hi, load_cnt, err_now, tmo_expire;

   spi_edge_detect u_edge (
      .clk   (clk),
      .reset (reset),
      .ss_n  (ss_n),
      .rise  (ss_rise),
      .fall  (ss_fall)
   );

`ifdef SPI_FRAME_TIMEOUT_EN
   localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (reset)                 tmo_cnt <= '0;
      else if (state == WAIT_LO) tmo_cnt <= tmo_cnt + 1'b1;
      else                       tmo_cnt <= '0;
   end

   assign tmo_expire = (state == WAIT_LO) && !ss_fall && (tmo_cnt == TMO_LAST);
`else
   assign tmo_expire = 1'b0;
`endif

   // A byte arriving in the cycle ss_n rises still belongs to the ending transfer.
   assign rx_ok     = rx_done & (~ss_n | ss_rise);
   assign cur_state = ss_fall ? WAIT_HI : state;
   assign lo_val    = {hi_reg, rx_data};

   always_comb begin
      nxt_state = cur_state;
      take_hi   = 1'b0;
      load_cnt  = 1'b0;
      err_now   = 1'b0;
      if (rx_ok) begin
         if (cur_state == WAIT_HI) begin
            if (rx_data[7:6] == HDR_MARK) begin
               take_hi   = 1'b1;
               nxt_state = WAIT_LO;
            end else begin
               err_now = 1'b1;
            end
         end else begin
            if (lo_val <= MAX_V) load_cnt = 1'b1;
            else                 err_now  = 1'b1;
            nxt_state = WAIT_HI;
         end
      end else if (tmo_expire) begin
         err_now   = 1'b1;
         nxt_state = WAIT_HI;
      end
      // Transfer ended with only the HI byte in hand: abort the frame.
      if (ss_rise && nxt_state == WAIT_LO) begin
         err_now   = 1'b1;
         nxt_state = WAIT_HI;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= WAIT_HI;
         hi_reg        <= '0;
         counter       <= '0;
         counter_valid <= 1'b0;
         frame_err     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= nxt_state;
         busy          <= (nxt_state == WAIT_LO);
         counter_valid <= load_cnt;
         frame_err     <= err_now;
         if (take_hi)  hi_reg  <= rx_data[5:0];
         if (load_cnt) counter <= lo_val;
      end
   end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Bench for spi_frame_decoder: directed frames plus random traffic against a
// byte-level frame model; accepted values are also tracked through a scoreboard queue.
module tb_spi_frame_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_done = 1'b0;
   logic        ss_n = 1'b1;
   logic [13:0] counter;
   logic        counter_valid, frame_err, busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int          m_counter = 0;
   bit          m_pending = 0;
   int          m_hi = 0;
   bit          m_ss_prev = 1;
   logic [13:0] exp_q[$];

   spi_frame_decoder #(
`ifdef SPI_FRAME_TIMEOUT_EN
      .TIMEOUT_CYCLES(100),
`endif
      .MAX_VALUE(9999)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_done       (rx_done),
      .ss_n          (ss_n),
      .counter       (counter),
      .counter_valid (counter_valid),
      .frame_err     (frame_err),
      .busy          (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every counter_valid pulse must match the oldest expected value.
   always @(negedge clk) begin
      if (counter_valid) begin
         if (exp_q.size() == 0) check("sb_unexpected_valid", counter_valid, 0);
         else                   check("sb_counter", counter, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int cycles, input string tag);
      reset = 1'b1;
      rx_done = 1'b0;
      m_pending = 0;
      m_counter = 0;
      m_ss_prev = 1;
      repeat (cycles) begin
         @(negedge clk);
         check({tag, "_err"}, frame_err, 0);
      end
      check({tag, "_counter"}, counter, 0);
      check({tag, "_valid"}, counter_valid, 0);
      check({tag, "_busy"}, busy, 0);
      reset = 1'b0;
   endtask

   // One cycle of stimulus followed by one idle cycle; the model applies the
   // frame rules to whatever the cycle carries.
   task automatic drive(input logic do_rx, input logic [7:0] b, input logic nss, input string tag);
      bit rise, fall, active, e_err, e_val;
      int v;
      rise   = nss && !m_ss_prev;
      fall   = !nss && m_ss_prev;
      active = do_rx && (!nss || rise);
      e_err  = 0;
      e_val  = 0;
      if (fall) m_pending = 0;
      if (active) begin
         if (!m_pending) begin
            if (b[7:6] == 2'b10) begin
               m_pending = 1;
               m_hi = int'(b[5:0]);
            end else begin
               e_err = 1;
            end
         end else begin
            v = m_hi * 256 + int'(b);
            m_pending = 0;
            if (v <= 9999) begin
               m_counter = v;
               e_val = 1;
               exp_q.push_back(14'(v));
            end else begin
               e_err = 1;
            end
         end
      end
      if (rise && m_pending) begin
         m_pending = 0;
         e_err = 1;
      end
      m_ss_prev = nss;

      rx_done = do_rx;
      rx_data = b;
      ss_n    = nss;
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = 8'($urandom);
      check({tag, "_valid"}, counter_valid, e_val);
      check({tag, "_err"}, frame_err, e_err);
      check({tag, "_busy"}, busy, m_pending);
      check({tag, "_counter"}, counter, m_counter);
      @(negedge clk);
      check({tag, "_valid_1cyc"}, counter_valid, 0);
      check({tag, "_err_1cyc"}, frame_err, 0);
   endtask

   task automatic send_frame(input int value, input string tag);
      logic [13:0] v;
      v = 14'(value);
      drive(1'b1, {2'b10, v[13:8]}, 1'b0, {tag, "_hi"});
      drive(1'b1, v[7:0], 1'b0, {tag, "_lo"});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int errs_seen;
      int kind, v;

      // T1 reset
      @(negedge clk);
      do_reset(5, "t1_reset");

      // T2 good frame
      drive(1'b1, 8'h9A, 1'b0, "t2_hi");
      drive(1'b1, 8'h0B, 1'b0, "t2_lo");
      check("t2_value", counter, 6667);

      // T3 range boundary
      drive(1'b1, 8'hA7, 1'b0, "t3_hi_over");
      drive(1'b1, 8'h10, 1'b0, "t3_lo_over");
      check("t3_keep", counter, 6667);
      drive(1'b1, 8'hA7, 1'b0, "t3_hi_max");
      drive(1'b1, 8'h0F, 1'b0, "t3_lo_max");
      check("t3_max", counter, 9999);

      // T4 bad marker, then recovery
      drive(1'b1, 8'h12, 1'b0, "t4_bad");
      drive(1'b1, 8'hC0, 1'b0, "t4_bad_c0");
      drive(1'b1, 8'h80, 1'b0, "t4_hi");
      drive(1'b1, 8'h05, 1'b0, "t4_lo");
      check("t4_value", counter, 5);

      // T5 abort on ss_n rise, then new transfer
      drive(1'b1, 8'h81, 1'b0, "t5_hi");
      drive(1'b0, 8'h00, 1'b1, "t5_rise");
      drive(1'b1, 8'h9A, 1'b1, "t5_ignored_rx");
      drive(1'b0, 8'h00, 1'b0, "t5_fall");
      drive(1'b1, 8'h80, 1'b0, "t5_hi2");
      drive(1'b1, 8'h2A, 1'b0, "t5_lo2");
      check("t5_value", counter, 42);

      // Same-cycle byte and ss_n rise: LO completes, HI aborts
      drive(1'b1, 8'h83, 1'b0, "sc_hi");
      drive(1'b1, 8'hE8, 1'b1, "sc_lo_rise");
      check("sc_lo_value", counter, 1000);
      drive(1'b0, 8'h00, 1'b0, "sc_fall");
      drive(1'b1, 8'h84, 1'b1, "sc_hi_rise");
      drive(1'b1, 8'h85, 1'b0, "sc_fall_with_hi");
      drive(1'b1, 8'h00, 1'b0, "sc_lo_after_fall");
      check("sc_fall_value", counter, 1280);

      // Reset mid-frame drops the frame silently
      drive(1'b1, 8'h90, 1'b0, "rm_hi");
      do_reset(2, "rm_reset");
      drive(1'b0, 8'h00, 1'b0, "rm_fall");
      send_frame(77, "rm_frame");

      // T6 timeout
      drive(1'b1, 8'h82, 1'b0, "t6_hi");
      errs_seen = 0;
      repeat (110) begin
         @(negedge clk);
         if (frame_err) errs_seen++;
      end
`ifdef SPI_FRAME_TIMEOUT_EN
      check("t6_err_count", errs_seen, 1);
      check("t6_busy", busy, 0);
      m_pending = 0;
`else
      check("t6_err_count", errs_seen, 0);
      check("t6_busy", busy, 1);
`endif
      drive(1'b1, 8'h00, 1'b0, "t6_next");

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 6));
         case (kind)
            0, 1, 2: send_frame(int'($urandom_range(0, 9999)), "rnd_good");
            3:       send_frame(int'($urandom_range(10000, 16383)), "rnd_over");
            4:       drive(1'b1, 8'($urandom), 1'b0, "rnd_byte");
            5: begin
               v = int'($urandom_range(0, 9999));
               drive(1'b1, {2'b10, 6'(v >> 8)}, 1'b0, "rnd_abort_hi");
               drive(1'b0, 8'h00, 1'b1, "rnd_abort_rise");
               drive(1'b0, 8'h00, 1'b0, "rnd_abort_fall");
            end
            default: begin
               v = int'($urandom_range(0, 9999));
               drive(1'b1, {2'b10, 6'(v >> 8)}, 1'b0, "rnd_end_hi");
               drive(1'b1, 8'(v), 1'b1, "rnd_end_lo_rise");
               drive(1'b0, 8'h00, 1'b0, "rnd_end_fall");
            end
         endcase
      end

      repeat (3) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
